count_seq_monitor: RTL
======================

# count_seq_monitor

Registered monitor stage downstream of the free-running `counter` block: it samples the counter's `count` output and checks that every sampled value is the previous one plus 1, modulo 2^WIDTH. It reports mismatches as a one-cycle pulse, a sticky flag and a saturating error count. It also captures the first bad value and counts legitimate wrap-arounds. It sits beside the DUT in the simulation environment and in silicon debug logic, and stays synthesizable.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count.
- `ERR_CNT_W`, 8: width of the saturating mismatch counter.
- `WRAP_CNT_W`, 16: width of the wrap counter; it rolls over modulo 2^WRAP_CNT_W.
- `SETTLE_CYC`, 2: clock cycles ignored after reset release, from 0 to 255.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: sample strobe; `count` is evaluated only when `en`=1.
- `count`  in  WIDTH: value under observation.
- `clr_err`  in  1: clears error state and forces resync.
- `locked`  out  1: tracking established.
- `err`  out  1: sticky mismatch flag.
- `err_pulse`  out  1: high for one cycle per mismatch.
- `err_cnt`  out  ERR_CNT_W: saturating mismatch count.
- `wrap_cnt`  out  WRAP_CNT_W: number of matched max→0 transitions.
- `exp_val`  out  WIDTH: value expected at the next sample.
- `bad_val`  out  WIDTH: `count` captured at the first mismatch since reset or clear.

## Operation
- One clock, `clk`. Synchronous, active-high reset, `rst`.
- State machine states: SETTLE, SYNC, TRACK.
- Reset values: state=SETTLE; settle counter=SETTLE_CYC; every output 0.
- **SETTLE:** the settle counter decrements every clock, regardless of `en`. When it is 0, the next state is SYNC. With SETTLE_CYC=0, the block leaves SETTLE on the first clock after reset. All samples are ignored.
- **SYNC:** on `en`=1, `exp_val` ← `count`+1 (mod 2^WIDTH), `locked` ← 1, state ← TRACK. No comparison is made in this state.
- **TRACK**, on `en`=1:
  - Match (`count`==`exp_val`): `exp_val` ← `count`+1. If `count`==0, `wrap_cnt` increments.
  - Mismatch: `err_pulse` ← 1, `err` ← 1, `err_cnt` increments and saturates at all-ones. `bad_val` ← `count`, but only if `err` was 0. `exp_val` ← `count`+1, so the block resyncs on the observed value and stays in TRACK.
  - A mismatch never increments `wrap_cnt`, even when `count`==0.
- `en`=0: all state holds and `err_pulse` ← 0.
- **`clr_err`:**
  - Clears `err`, `err_cnt`, `bad_val` and `err_pulse`, and sets `locked` ← 0.
  - State ← SYNC, from TRACK or SYNC; in SETTLE it is ignored.
  - `wrap_cnt` and `exp_val` are preserved.
- **Priority:** `rst` > `clr_err` > sample. A sample coinciding with `clr_err` is dropped.
- **Arithmetic:** `count`+1 is computed in WIDTH bits and wraps naturally. The `wrap_cnt` increment wraps. The `err_cnt` increment saturates.

## Timing
- All outputs are registered.
- The effect of a sample taken at edge N is visible after edge N, i.e. in the following cycle. There are no combinational paths from inputs to outputs.
- `err_pulse` is high for exactly one cycle per mismatched sample. Back-to-back mismatched samples give a continuous high.
- **After `rst` deasserts:**
  - SETTLE occupies SETTLE_CYC clocks.
  - The first `en` sample in SYNC raises `locked` one cycle later.
  - The next `en` sample is the first one compared.
- **`rst` mid-operation:** every output returns to its reset value on the next edge, and SETTLE repeats in full.

## Structure
- Shared package `count_mon_pkg`: `mon_state_t` enum (SETTLE, SYNC, TRACK) and default constants `CNT_WIDTH`=4, `ERR_CNT_W`=8, `WRAP_CNT_W`=16, `SETTLE_CYC`=2.
- One sub-module: `sat_counter`.
  - Parameter: width.
  - Ports: `inc` and `clr`.
  - Saturates at all-ones.
  - Used for `err_cnt`.
- The state machine, comparator, wrap counter and capture registers stay in the top module.

## Test plan
All scenarios use WIDTH=4.
1. SETTLE_CYC=2; `rst` for 2 cycles, then `en`=1 with a ramp 0..15, 0..3 → `locked`=1 one cycle after the first SYNC sample; `err`=0, `err_cnt`=0, `wrap_cnt`=1 at end.
2. In TRACK, feed 5, 6, 8, 9 → `err_pulse` high exactly one cycle after 8 is sampled; then `err`=1, `err_cnt`=1, `bad_val`=8, and `exp_val`=10 after 9; no further pulses.
3. ERR_CNT_W=2; in TRACK, hold `count`=3 for 6 `en` samples → `err_cnt` goes 1, 2, 3, 3, 3, 3; `err_pulse` stays high continuously; `bad_val`=3.
4. Toggle `en` 1,0,1,0…; the ramp advances only on `en`=1 cycles and `count`=15 is driven during `en`=0 cycles → no error, `err_cnt`=0.
5. With `err`=1 and `wrap_cnt`=2: assert `clr_err` while `en`=1 and `count` is wrong → next cycle `err`=0, `err_cnt`=0, `bad_val`=0, `err_pulse`=0, `locked`=0, `wrap_cnt`=2. The next `en` sample resyncs without error.
6. Assert `rst` mid-TRACK with `err`=1 and `wrap_cnt`=5 → all outputs 0 on the next edge; after release, SETTLE lasts exactly SETTLE_CYC cycles before `locked` can rise.

Source files
------------

// File: rtl/count_mon_pkg.sv
// count_mon_pkg
// Shared types and default constants for the count sequence monitor.
//   mon_state_t : SETTLE (ignore samples after reset), SYNC (take a reference
//                 sample), TRACK (compare every sample with the expected value)
//   CNT_WIDTH, ERR_CNT_W, WRAP_CNT_W, SETTLE_CYC : default parameter values
package count_mon_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SYNC   = 2'd1,
    TRACK  = 2'd2
  } mon_state_t;

  localparam int CNT_WIDTH  = 4;
  localparam int ERR_CNT_W  = 8;
  localparam int WRAP_CNT_W = 16;
  localparam int SETTLE_CYC = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : add one unless already saturated
//   value : registered count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
// Watches a free-running counter and checks that each sampled value is the
// previous one plus 1 (mod 2^WIDTH). Mismatches give a one-cycle pulse, a
// sticky flag, a saturating count and a capture of the first bad value.
// Matched max->0 transitions are counted in wrap_cnt.
//   clk, rst  : clock and synchronous active-high reset
//   en        : sample strobe for count
//   count     : observed value
//   clr_err   : clears error state and forces a resync
//   locked    : a reference sample has been taken, comparisons are live
//   err       : sticky mismatch flag
//   err_pulse : one cycle per mismatched sample
//   err_cnt   : saturating mismatch count
//   wrap_cnt  : matched wrap-arounds, rolls over
//   exp_val   : value expected at the next sample
//   bad_val   : count captured at the first mismatch since reset/clear
module count_seq_monitor #(
  parameter int WIDTH      = count_mon_pkg::CNT_WIDTH,
  parameter int ERR_CNT_W  = count_mon_pkg::ERR_CNT_W,
  parameter int WRAP_CNT_W = count_mon_pkg::WRAP_CNT_W,
  parameter int SETTLE_CYC = count_mon_pkg::SETTLE_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      count,
  input  logic                  clr_err,
  output logic                  locked,
  output logic                  err,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]      exp_val,
  output logic [WIDTH-1:0]      bad_val
);
  import count_mon_pkg::*;

  mon_state_t state;
  logic [7:0] settle_cnt;

  // clr_err has no effect while settling.
  logic clr_eff;
  logic mismatch;
  logic err_inc;

  assign clr_eff  = clr_err && (state != SETTLE);
  assign mismatch = (count != exp_val);
  assign err_inc  = (state == TRACK) && !clr_eff && en && mismatch;

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_eff),
    .inc   (err_inc),
    .value (err_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= 8'(SETTLE_CYC);
      locked     <= 1'b0;
      err        <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_cnt   <= '0;
      exp_val    <= '0;
      bad_val    <= '0;
    end else if (state == SETTLE) begin
      err_pulse <= 1'b0;
      // Leave on the clock where the counter would reach zero, so SETTLE
      // lasts SETTLE_CYC clocks (and a single clock when SETTLE_CYC is 0).
      if (settle_cnt <= 8'd1) state <= SYNC;
      if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
    end else if (clr_eff) begin
      // wrap_cnt and exp_val intentionally survive a clear.
      err       <= 1'b0;
      err_pulse <= 1'b0;
      bad_val   <= '0;
      locked    <= 1'b0;
      state     <= SYNC;
    end else if (en) begin
      exp_val <= count + WIDTH'(1);
      if (state == SYNC) begin
        locked    <= 1'b1;
        err_pulse <= 1'b0;
        state     <= TRACK;
      end else if (!mismatch) begin
        err_pulse <= 1'b0;
        if (count == '0) wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end else begin
        // Resync on the observed value; only the first bad value is kept.
        err_pulse <= 1'b1;
        err       <= 1'b1;
        if (!err) bad_val <= count;
      end
    end else begin
      err_pulse <= 1'b0;
    end
  end

endmodule
